// File: rtl/ins_fetch_queue_pkg.sv
// rtl/ins_fetch_queue_pkg.sv - shared opcode constants, fetch FSM states and J-immediate helper
package ins_fetch_queue_pkg;

    // Major opcode of JAL; its target is resolved locally without the predictor.
    localparam logic [6:0] JAL_type = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_BUSY  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    // Sign-extended J-type immediate: inst[31], inst[19:12], inst[20], inst[30:21], 0.
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ins_fetch_queue_if.sv
// rtl/ins_fetch_queue_if.sv - fetch queue bus to i-cache, predictor, ROB and dispatcher
interface ins_fetch_queue_if #(
    parameter int XLEN         = 32,
    parameter int IQ_DEPTH_LOG = 3
);
    logic                    rdy;
    logic                    issue_stall;
    logic                    if_valid;
    logic                    if_jump;
    logic [XLEN-1:0]         dispatch_inst;
    logic [XLEN-1:0]         dispatch_pc;
    logic                    suggest_jump;
    logic [XLEN-1:0]         suggest_pc;
    logic [XLEN-1:0]         predict_inst;
    logic [XLEN-1:0]         predict_pc;
    logic                    should_reset;
    logic [XLEN-1:0]         reset_pc;
    logic                    cache_valid;
    logic [XLEN-1:0]         cache_inst;
    logic [XLEN-1:0]         cache_pc;
    logic                    fetch_enable;
    logic [IQ_DEPTH_LOG:0]   iq_count;

    // Fetch unit side.
    modport master (
        input  rdy, issue_stall, suggest_jump, suggest_pc, should_reset, reset_pc,
               cache_valid, cache_inst,
        output if_valid, if_jump, dispatch_inst, dispatch_pc, predict_inst, predict_pc,
               cache_pc, fetch_enable, iq_count
    );

    // Environment side (cache, predictor, ROB, dispatcher).
    modport slave (
        output rdy, issue_stall, suggest_jump, suggest_pc, should_reset, reset_pc,
               cache_valid, cache_inst,
        input  if_valid, if_jump, dispatch_inst, dispatch_pc, predict_inst, predict_pc,
               cache_pc, fetch_enable, iq_count
    );
endinterface

// File: rtl/ins_fetch_queue_iq_fifo.sv
// rtl/ins_fetch_queue_iq_fifo.sv - circular instruction buffer with push/pop/flush and head output
module ins_fetch_queue_iq_fifo #(
    parameter int DEPTH_LOG = 3,
    parameter int WIDTH     = 65
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_flush,
    input  logic [WIDTH-1:0]     i_data,
    output logic [DEPTH_LOG:0]   o_count,
    output logic [WIDTH-1:0]     o_head_data
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;

    // Pointer and occupancy update; flush empties the queue and dominates push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (i_push) r_tail <= r_tail + DEPTH_LOG'(1);
                if (i_pop)  r_head <= r_head + DEPTH_LOG'(1);
                case ({i_push, i_pop})
                    2'b10:   r_count <= r_count + (DEPTH_LOG+1)'(1);
                    2'b01:   r_count <= r_count - (DEPTH_LOG+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage; contents are only observed while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (i_en && i_push && !i_flush) begin
            r_mem[r_tail] <= i_data;
        end
    end

    assign o_count     = r_count;
    assign o_head_data = (r_count != '0) ? r_mem[r_head] : '0;

endmodule

// File: rtl/ins_fetch_queue.sv
// rtl/ins_fetch_queue.sv - instruction fetcher with IQ_DEPTH-entry queue; IQ_BYPASS_EN enables same-cycle bypass
module ins_fetch_queue
    import ins_fetch_queue_pkg::*;
#(
    parameter int              IQ_DEPTH_LOG = 3,
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0
) (
    input  logic              clk,
    input  logic              rst,
    ins_fetch_queue_if.master bus
);
    localparam int                  IQ_DEPTH   = 1 << IQ_DEPTH_LOG;
    localparam int                  EW         = 2 * XLEN + 1;
    localparam logic [IQ_DEPTH_LOG:0] FULL_COUNT = (IQ_DEPTH_LOG+1)'(IQ_DEPTH);

    fetch_state_e          r_state, w_state_nxt;
    logic [XLEN-1:0]       r_pc, w_pc_nxt;
    logic [XLEN-1:0]       r_cache_pc, w_cache_pc_nxt;
    logic                  r_fetch_en, w_fetch_en_nxt;

    logic                  w_is_jal;
    logic                  w_resp_jump;
    logic [XLEN-1:0]       w_resp_pc;
    logic                  w_take_resp;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_q_valid;
    logic [IQ_DEPTH_LOG:0] w_count;
    logic [EW-1:0]         w_push_data;
    logic [EW-1:0]         w_head_data;

    // Next-PC for the response in flight: JAL resolved here, everything else from the predictor.
    assign w_is_jal    = (bus.cache_inst[6:0] == JAL_type);
    assign w_resp_pc   = w_is_jal ? (r_pc + XLEN'($signed(j_imm(bus.cache_inst[31:0]))))
                                  : bus.suggest_pc;
    assign w_resp_jump = w_is_jal ? 1'b1 : bus.suggest_jump;

    // A live response is one answering the current pc with no flush pending.
    assign w_take_resp = bus.cache_valid && (r_state == FETCH_BUSY) && !bus.should_reset;

`ifdef IQ_BYPASS_EN
    assign w_bypass = bus.rdy && w_take_resp && (w_count == '0) && !bus.issue_stall;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_take_resp && !w_bypass;
    assign w_q_valid   = (w_count != '0);
    assign w_pop       = w_q_valid && !bus.issue_stall && !bus.should_reset;
    assign w_push_data = {bus.cache_inst, r_pc, w_resp_jump};

    ins_fetch_queue_iq_fifo #(
        .DEPTH_LOG (IQ_DEPTH_LOG),
        .WIDTH     (EW)
    ) u_iq_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_en        (bus.rdy),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (bus.should_reset),
        .i_data      (w_push_data),
        .o_count     (w_count),
        .o_head_data (w_head_data)
    );

    // Fetch FSM next-state: issue while room, accept or discard the single outstanding response.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cache_pc_nxt = r_cache_pc;
        w_fetch_en_nxt = r_fetch_en;
        case (r_state)
            FETCH_IDLE: begin
                if (bus.should_reset) begin
                    w_pc_nxt       = bus.reset_pc;
                    w_fetch_en_nxt = 1'b0;
                end else if (w_count < FULL_COUNT) begin
                    w_fetch_en_nxt = 1'b1;
                    w_cache_pc_nxt = r_pc;
                    w_state_nxt    = FETCH_BUSY;
                end else begin
                    w_fetch_en_nxt = 1'b0;
                end
            end
            FETCH_BUSY: begin
                if (bus.should_reset) begin
                    w_pc_nxt = bus.reset_pc;
                    if (bus.cache_valid) begin
                        w_fetch_en_nxt = 1'b0;
                        w_state_nxt    = FETCH_IDLE;
                    end else begin
                        w_state_nxt    = FETCH_DRAIN;
                    end
                end else if (bus.cache_valid) begin
                    w_pc_nxt       = w_resp_pc;
                    w_fetch_en_nxt = 1'b0;
                    w_state_nxt    = FETCH_IDLE;
                end
            end
            FETCH_DRAIN: begin
                if (bus.should_reset) w_pc_nxt = bus.reset_pc;
                if (bus.cache_valid) begin
                    w_fetch_en_nxt = 1'b0;
                    w_state_nxt    = FETCH_IDLE;
                end
            end
            default: begin
                w_fetch_en_nxt = 1'b0;
                w_state_nxt    = FETCH_IDLE;
            end
        endcase
    end

    // Fetch FSM registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH_IDLE;
            r_pc       <= RESET_PC;
            r_cache_pc <= '0;
            r_fetch_en <= 1'b0;
        end else if (bus.rdy) begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cache_pc <= w_cache_pc_nxt;
            r_fetch_en <= w_fetch_en_nxt;
        end
    end

    // Dispatch view: bypassed response when enabled, otherwise the queue head.
    always_comb begin
        if (w_bypass) begin
            bus.if_valid      = 1'b1;
            bus.dispatch_inst = bus.cache_inst;
            bus.dispatch_pc   = r_pc;
            bus.if_jump       = w_resp_jump;
        end else begin
            bus.if_valid      = w_q_valid;
            bus.dispatch_inst = w_head_data[EW-1:XLEN+1];
            bus.dispatch_pc   = w_head_data[XLEN:1];
            bus.if_jump       = w_head_data[0];
        end
    end

    assign bus.predict_inst = bus.cache_inst;
    assign bus.predict_pc   = r_pc;
    assign bus.cache_pc     = r_cache_pc;
    assign bus.fetch_enable = r_fetch_en;
    assign bus.iq_count     = w_count;

endmodule
